// File: rtl/adaptive_threshold_pkg.sv
// Shared sizing defaults and the pixel-write record passed from the box filter
// lanes to the display write port.
package adaptive_threshold_pkg;

  localparam int WIDTH_BITS_DEFAULT        = 8;
  localparam int HEIGHT_BITS_DEFAULT       = 8;
  localparam int NUM_PARALLEL_BITS_DEFAULT = 2;

  typedef struct packed {
    logic [HEIGHT_BITS_DEFAULT-1:0] row;
    logic [WIDTH_BITS_DEFAULT-1:0]  col;
    logic                           data;
  } pixel_write_t;

endpackage

// File: rtl/lane_fifo.sv
// Two-entry FIFO for one filter lane; push is ignored when full, pop when empty.
module lane_fifo
  import adaptive_threshold_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  pixel_write_t din,
  output pixel_write_t dout,
  output logic         full,
  output logic         empty
);

  pixel_write_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/result_write_collector.sv
// Merges the parallel box-filter result lanes into one display write port and
// counts completed pixels per frame. Define RESULT_COLLECTOR_STATS_EN for oStallCount.
module result_write_collector
  import adaptive_threshold_pkg::*;
#(
  parameter int WIDTH_BITS        = WIDTH_BITS_DEFAULT,
  parameter int HEIGHT_BITS       = HEIGHT_BITS_DEFAULT,
  parameter int NUM_PARALLEL_BITS = NUM_PARALLEL_BITS_DEFAULT,
  localparam int NUM_PARALLEL     = 2 ** NUM_PARALLEL_BITS
) (
  input  logic                                    clock,
  input  logic                                    reset,
  // Handshakes: a lane write moves when iWren[i] && oReady[i]; a display write
  // completes when oWren && iMemReady, and the output holds until then.
  input  logic [NUM_PARALLEL-1:0][WIDTH_BITS-1:0]  iCol,
  input  logic [NUM_PARALLEL-1:0][HEIGHT_BITS-1:0] iRow,
  input  logic [NUM_PARALLEL-1:0]                  iData,
  input  logic [NUM_PARALLEL-1:0]                  iWren,
  output logic [NUM_PARALLEL-1:0]                  oReady,
  output logic [7:0]                               oX,
  output logic [7:0]                               oY,
  output logic [2:0]                               oR,
  output logic [2:0]                               oG,
  output logic [2:0]                               oB,
  output logic                                     oWren,
  input  logic                                     iMemReady,
  input  logic                                     iClear,
`ifdef RESULT_COLLECTOR_STATS_EN
  output logic [15:0]                              oStallCount,
`endif
  output logic [WIDTH_BITS+HEIGHT_BITS:0]          oPixelCount,
  output logic                                     oFrameDone
);

  localparam int COUNT_BITS = WIDTH_BITS + HEIGHT_BITS + 1;
  localparam logic [COUNT_BITS-1:0] FRAME_PIXELS = COUNT_BITS'(1) << (WIDTH_BITS + HEIGHT_BITS);

  pixel_write_t                 lane_in   [NUM_PARALLEL];
  pixel_write_t                 lane_head [NUM_PARALLEL];
  logic [NUM_PARALLEL-1:0]      lane_full;
  logic [NUM_PARALLEL-1:0]      lane_empty;
  logic [NUM_PARALLEL-1:0]      lane_pop;
  logic [NUM_PARALLEL_BITS-1:0] rr_ptr;
  logic [NUM_PARALLEL_BITS-1:0] grant_idx;
  logic [NUM_PARALLEL_BITS-1:0] cand;
  logic                         grant_valid;
  logic                         write_done;
  logic                         out_load;

  assign write_done = oWren && iMemReady;
  assign out_load   = !oWren || write_done;
  assign oReady     = ~lane_full;

  for (genvar i = 0; i < NUM_PARALLEL; i++) begin : g_lane
    assign lane_in[i] = '{row:  HEIGHT_BITS_DEFAULT'(iRow[i]),
                          col:  WIDTH_BITS_DEFAULT'(iCol[i]),
                          data: iData[i]};

    lane_fifo u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (iWren[i]),
      .pop   (lane_pop[i]),
      .din   (lane_in[i]),
      .dout  (lane_head[i]),
      .full  (lane_full[i]),
      .empty (lane_empty[i])
    );
  end

  // First non-empty lane at or after the round-robin pointer wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = rr_ptr;
    cand        = rr_ptr;
    lane_pop    = '0;
    for (int k = 0; k < NUM_PARALLEL; k++) begin
      cand = rr_ptr + NUM_PARALLEL_BITS'(k);
      if (!grant_valid && !lane_empty[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
    if (out_load && grant_valid) lane_pop[grant_idx] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      oWren  <= 1'b0;
      oX     <= '0;
      oY     <= '0;
      oR     <= '0;
      oG     <= '0;
      oB     <= '0;
      rr_ptr <= '0;
    end else if (out_load) begin
      oWren <= grant_valid;
      if (grant_valid) begin
        oX     <= 8'(lane_head[grant_idx].row);
        oY     <= 8'(lane_head[grant_idx].col);
        oR     <= {3{lane_head[grant_idx].data}};
        oG     <= {3{lane_head[grant_idx].data}};
        oB     <= {3{lane_head[grant_idx].data}};
        rr_ptr <= grant_idx + NUM_PARALLEL_BITS'(1);
      end
    end
  end

  // Clear takes priority over a write completing in the same cycle.
  always_ff @(posedge clock) begin
    if (reset || iClear) begin
      oPixelCount <= '0;
      oFrameDone  <= 1'b0;
    end else begin
      if (oPixelCount == FRAME_PIXELS) oFrameDone <= 1'b1;
      if (write_done && (oPixelCount < FRAME_PIXELS)) oPixelCount <= oPixelCount + COUNT_BITS'(1);
    end
  end

`ifdef RESULT_COLLECTOR_STATS_EN
  logic stall_cycle;

  assign stall_cycle = (oWren && !iMemReady) || (|(iWren & ~oReady));

  always_ff @(posedge clock) begin
    if (reset || iClear) begin
      oStallCount <= '0;
    end else if (stall_cycle && (oStallCount != 16'hFFFF)) begin
      oStallCount <= oStallCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_result_write_collector.sv
// Randomized scoreboard bench for result_write_collector: per-lane ordered expectations,
// frame pixel accounting model, and directed latency/arbitration/stall/reset cases.
module tb_result_write_collector;
  import adaptive_threshold_pkg::*;

  localparam int NP      = 4;
  localparam int MAX_PIX = 65536;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NP-1:0][7:0] iCol;
  logic [NP-1:0][7:0] iRow;
  logic [NP-1:0]     iData;
  logic [NP-1:0]     iWren;
  logic [NP-1:0]     oReady;
  logic [7:0]        oX;
  logic [7:0]        oY;
  logic [2:0]        oR;
  logic [2:0]        oG;
  logic [2:0]        oB;
  logic              oWren;
  logic              iMemReady;
  logic              iClear;
  logic [16:0]       oPixelCount;
  logic              oFrameDone;
`ifdef RESULT_COLLECTOR_STATS_EN
  logic [15:0]       oStallCount;
`endif

  result_write_collector dut (
    .clock       (clock),
    .reset       (reset),
    .iCol        (iCol),
    .iRow        (iRow),
    .iData       (iData),
    .iWren       (iWren),
    .oReady      (oReady),
    .oX          (oX),
    .oY          (oY),
    .oR          (oR),
    .oG          (oG),
    .oB          (oB),
    .oWren       (oWren),
    .iMemReady   (iMemReady),
    .iClear      (iClear),
`ifdef RESULT_COLLECTOR_STATS_EN
    .oStallCount (oStallCount),
`endif
    .oPixelCount (oPixelCount),
    .oFrameDone  (oFrameDone)
  );

  // Clock and watchdog
  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard state: entry = {lane[1:0], row[7:0], col[7:0], data}
  int            n_checks = 0;
  int            n_pass   = 0;
  logic [18:0]   exp_q[$];
  logic [NP-1:0] acc_mask = '0;
  int            seq = 0;
  int            issue_left = 1 << 30;
  int            m_count = 0;
  logic          m_done = 1'b0;
  int            m_stall = 0;
  bit            rr_check = 1'b0;
  bit            rr_first = 1'b1;
  int            rr_last = 0;
  bit            saw_not_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic score_output();
    int          idx = -1;
    int          bad = 0;
    logic [18:0] e;
    for (int j = 0; j < exp_q.size(); j++)
      if (idx < 0 && exp_q[j][16:1] == {oX, oY}) idx = j;
    if (idx < 0) begin
      n_checks++;
      $display("FAIL unexpected_write: got x=%0d y=%0d, expected no write at this address", oX, oY);
    end else begin
      e = exp_q[idx];
      for (int j = 0; j < idx; j++)
        if (exp_q[j][18:17] == e[18:17]) bad = 1;
      check("lane_order", 32'(bad), 32'd0);
      check("write_data", 32'({oX, oY, oR, oG, oB}), 32'({e[16:1], {9{e[0]}}}));
      if (rr_check) begin
        check("rr_lane", 32'(e[18:17]), rr_first ? 32'd0 : 32'((rr_last + 1) % NP));
        rr_first = 1'b0;
        rr_last  = int'(e[18:17]);
      end
      exp_q.delete(idx);
    end
  endtask

  // Monitor: samples mid-cycle, decides what the coming edge will do
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      m_count  = 0;
      m_done   = 1'b0;
      m_stall  = 0;
      acc_mask = '0;
    end else begin
      check("pixel_count", 32'(oPixelCount), 32'(m_count));
      check("frame_done", 32'(oFrameDone), 32'(m_done));
`ifdef RESULT_COLLECTOR_STATS_EN
      check("stall_count", 32'(oStallCount), 32'(m_stall));
`endif
      if (oWren && iMemReady) score_output();
      for (int i = 0; i < NP; i++)
        if (iWren[i] && oReady[i]) exp_q.push_back({2'(i), iRow[i], iCol[i], iData[i]});
      if (rr_check && oReady != '1) saw_not_ready = 1'b1;
      acc_mask = iWren & oReady;
      if (iClear) m_stall = 0;
      else if (((oWren && !iMemReady) || ((iWren & ~oReady) != '0)) && m_stall < 65535) m_stall++;
      if (iClear) begin
        m_count = 0;
        m_done  = 1'b0;
      end else begin
        if (m_count == MAX_PIX) m_done = 1'b1;
        if (oWren && iMemReady && m_count < MAX_PIX) m_count++;
      end
    end
  end

  // Driver: refills a lane only after its current write is accepted
  task automatic drive(input int cycles, input logic [NP-1:0] lanes, input int prob);
    logic [15:0] rc;
    repeat (cycles) begin
      @(posedge clock);
      #1;
      for (int i = 0; i < NP; i++) begin
        if (!iWren[i] || acc_mask[i]) begin
          if (lanes[i] && issue_left > 0 && int'($urandom_range(99)) < prob) begin
            rc       = 16'(seq * 40503);
            seq++;
            iRow[i]  = rc[15:8];
            iCol[i]  = rc[7:0];
            iData[i] = 1'($urandom);
            iWren[i] = 1'b1;
            issue_left--;
          end else begin
            iWren[i] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((iWren != '0 || exp_q.size() != 0) && k < 300) begin
      drive(1, '0, 0);
      k++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_clear();
    @(posedge clock);
    #1 iClear = 1'b1;
    @(posedge clock);
    #1 iClear = 1'b0;
  endtask

  initial begin
    int k;
    iCol = '0; iRow = '0; iData = '0; iWren = '0;
    iMemReady = 1'b1; iClear = 1'b0; reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clock);
    check("rst_owren", 32'(oWren), 32'd0);
    check("rst_oready", 32'(oReady), 32'hF);
    check("rst_xy", 32'({oX, oY}), 32'd0);
    check("rst_rgb", 32'({oR, oG, oB}), 32'd0);
    check("rst_count", 32'(oPixelCount), 32'd0);

    // Single lane-1 write, two-cycle latency
    @(posedge clock);
    #1;
    iRow[1] = 8'd5; iCol[1] = 8'd9; iData[1] = 1'b1; iWren[1] = 1'b1;
    @(posedge clock);
    #1 iWren[1] = 1'b0;
    @(negedge clock);
    check("lat_t1_owren", 32'(oWren), 32'd0);
    @(negedge clock);
    check("lat_t2_owren", 32'(oWren), 32'd1);
    check("lat_t2_xy", 32'({oX, oY}), 32'h0509);
    check("lat_t2_rgb", 32'({oR, oG, oB}), 32'h1FF);
    drain("single");

`ifdef RESULT_COLLECTOR_STATS_EN
    // Seven output-stall cycles with no blocked lane
    @(posedge clock);
    #1; iClear = 1'b1; iMemReady = 1'b0;
    @(posedge clock);
    #1; iClear = 1'b0;
    iRow[0] = 8'd200; iCol[0] = 8'd3; iData[0] = 1'b0; iWren[0] = 1'b1;
    @(posedge clock);
    #1 iWren[0] = 1'b0;
    k = 0;
    @(negedge clock);
    while (!oWren && k < 10) begin
      @(negedge clock);
      k++;
    end
    check("stat_owren_seen", 32'(oWren), 32'd1);
    repeat (7) @(posedge clock);
    #1 iMemReady = 1'b1;
    @(negedge clock);
    check("stat_stall_7", 32'(oStallCount), 32'd7);
    drain("stat");
`endif

    // All lanes saturated: strict rotation from lane 0, backpressure seen
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    rr_check = 1'b1;
    rr_first = 1'b1;
    drive(40, 4'hF, 100);
    rr_check = 1'b0;
    check("rr_backpressure_seen", 32'(saw_not_ready), 32'd1);
    drain("rr");

    // Output stalled while lane 0 streams
    @(posedge clock);
    #1 iMemReady = 1'b0;
    drive(10, 4'b0001, 100);
    @(negedge clock);
    check("stall_ready0", 32'(oReady[0]), 32'd0);
    check("stall_owren_held", 32'(oWren), 32'd1);
    @(posedge clock);
    #1 iMemReady = 1'b1;
    drain("stall");

    // Full frame of random writes, saturation, then clear
    pulse_clear();
    issue_left = MAX_PIX;
    k = 0;
    while (issue_left > 0 && k < 90000) begin
      drive(1, 4'hF, 90);
      k++;
    end
    check("frame_issued", 32'(issue_left), 32'd0);
    drain("frame");
    repeat (2) @(negedge clock);
    check("frame_count", 32'(oPixelCount), 32'(MAX_PIX));
    check("frame_done_set", 32'(oFrameDone), 32'd1);
    issue_left = 5;
    drive(8, 4'b0100, 100);
    drain("sat");
    repeat (2) @(negedge clock);
    check("sat_count", 32'(oPixelCount), 32'(MAX_PIX));
    pulse_clear();
    @(negedge clock);
    check("clear_count", 32'(oPixelCount), 32'd0);
    check("clear_done", 32'(oFrameDone), 32'd0);

    // Reset with every FIFO full and the output register loaded
    issue_left = 1 << 30;
    @(posedge clock);
    #1 iMemReady = 1'b0;
    drive(6, 4'hF, 100);
    @(posedge clock);
    #1; reset = 1'b1; iWren = '0;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("mid_rst_owren", 32'(oWren), 32'd0);
    check("mid_rst_ready", 32'(oReady), 32'hF);
    @(posedge clock);
    #1 iMemReady = 1'b1;
    repeat (10) @(negedge clock);
    check("mid_rst_no_stale", 32'(oPixelCount), 32'd0);
    check("mid_rst_idle", 32'(oWren), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/result_write_collector.md
RESULT_WRITE_COLLECTOR -- requirements
Module: result_write_collector

Interface
REQ-001 SHALL have parameter WIDTH_BITS, default 8, column address width.
REQ-002 SHALL have parameter HEIGHT_BITS, default 8, row address width.
REQ-003 SHALL have parameter NUM_PARALLEL_BITS, default 2; lane count NUM_PARALLEL = 2**NUM_PARALLEL_BITS.
REQ-004 SHALL have port clock, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have ports iCol/iRow/iData/iWren, inputs, per lane WIDTH_BITS/HEIGHT_BITS/1/1, box-filter result write streams.
REQ-007 SHALL have port oReady, output, NUM_PARALLEL, per-lane accept; a write transfers when iWren[i] && oReady[i].
REQ-008 SHALL have ports oX, oY, outputs, 8 each, display write address.
REQ-009 SHALL have ports oR, oG, oB, outputs, 3 each, display pixel colour.
REQ-010 SHALL have port oWren, output, 1, display write valid.
REQ-011 SHALL have port iMemReady, input, 1; a display write completes when oWren && iMemReady.
REQ-012 SHALL have port iClear, input, 1, synchronous clear of frame accounting.
REQ-013 SHALL have ports oPixelCount (WIDTH_BITS+HEIGHT_BITS+1 bits) and oFrameDone (1), outputs.

Function
REQ-014 SHALL buffer each lane in an independent 2-entry FIFO; oReady[i] = FIFO i not full, no same-cycle pass-through when full.
REQ-015 SHALL hold one output register; it loads when empty or when oWren && iMemReady in the same cycle.
REQ-016 SHALL grant one non-empty lane per load, round-robin; the pointer moves to granted lane + 1 modulo NUM_PARALLEL, wrapping from NUM_PARALLEL-1 to 0.
REQ-017 SHALL map lane row to oX and lane column to oY, and drive oR = oG = oB = {3{data}}.
REQ-018 SHALL give latency 2: lane write accepted in cycle t appears with oWren=1 in cycle t+2 when uncontended and the output register is free.
REQ-019 SHALL hold oX/oY/oR/oG/oB/oWren stable while oWren && !iMemReady.
REQ-020 SHALL preserve per-lane order and never drop or duplicate a write.
REQ-021 SHALL increment oPixelCount by one per completed display write, saturating at WIDTH*HEIGHT.
REQ-022 SHALL set oFrameDone (sticky) in the cycle after oPixelCount reaches WIDTH*HEIGHT.
REQ-023 SHALL, on iClear, zero oPixelCount and oFrameDone next cycle without flushing FIFOs; if a write completes that cycle, clear wins.

Reset
REQ-024 SHALL on reset empty all FIFOs, set oReady to all-ones the cycle after reset deasserts, zero oWren/oX/oY/oR/oG/oB, oPixelCount, oFrameDone, and set the arbiter pointer to lane 0.
REQ-025 SHALL, on reset mid-frame, discard all buffered and in-flight writes.

Configuration
REQ-026 SHALL, with RESULT_COLLECTOR_STATS_EN defined, add output oStallCount (16 bits, saturating), incremented each cycle with oWren && !iMemReady or any iWren[i] && !oReady[i], cleared by reset and iClear.
REQ-027 SHALL, without RESULT_COLLECTOR_STATS_EN, omit oStallCount and its logic entirely.

Structure
REQ-028 SHALL take WIDTH_BITS, HEIGHT_BITS, NUM_PARALLEL_BITS defaults and a packed pixel-write typedef (row, col, data) from shared package adaptive_threshold_pkg.
REQ-029 SHALL instantiate per lane one sub-module lane_fifo (2-entry, push/pop, full/empty).

Verification
REQ-030 Single lane 1 writes row=5,col=9,data=1 with iMemReady=1 -> oWren cycle t+2, oX=5, oY=9, oR=oG=oB=3'b111.
REQ-031 All four lanes write every cycle, iMemReady=1 -> output lanes cycle 0,1,2,3,0..., oReady deasserts after 2 queued, no loss, order kept per lane.
REQ-032 iMemReady=0 for 10 cycles with lane 0 streaming -> outputs held, oReady[0]=0 after 2 more accepts, all writes emitted once iMemReady=1.
REQ-033 Stream 65536 writes over all lanes -> oPixelCount=65536, oFrameDone=1 next cycle; iClear -> both 0.
REQ-034 Assert reset with FIFOs full -> oWren=0 next cycle, all oReady=1 after release, no stale write emitted.
REQ-035 With RESULT_COLLECTOR_STATS_EN, hold iMemReady=0 for 7 cycles with oWren=1 and no lane blocked -> oStallCount=7.
